// File: rtl/fp_align_stage.sv
// Two-stage FP add/sub alignment: S1 compares and swaps, S2 shifts the smaller mantissa.
// Define FP_ALIGN_DENORM_EN to keep denormals; otherwise exponent-0 operands flush to zero.
module fp_align_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] mant_big,
    output logic [24:0] mant_small,
    output logic [7:0]  exp_out,
    output logic        sign_out,
    output logic        eff_sub,
    output logic        sticky
);

    logic        stall;
    logic        s1_valid;
    logic        s2_valid;

    logic [7:0]  exp_a, exp_b;
    logic [23:0] sig_a, sig_b;
    logic        a_big;
    logic [24:0] big_c, small_c;
    logic [7:0]  ebig_c, esmall_c, d_c;
    logic        sign_c, eff_c;

    logic [24:0] s1_big, s1_small;
    logic [7:0]  s1_exp, s1_d;
    logic        s1_sign, s1_eff;

    logic [24:0] shifted, lost_mask;
    logic        sticky_c;

    assign stall     = s2_valid && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = s2_valid;

    // Unpack both operands, pick the larger magnitude and compute the exponent gap.
    always_comb begin
`ifdef FP_ALIGN_DENORM_EN
        exp_a = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        exp_b = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        sig_a = {(a[30:23] != 8'd0), a[22:0]};
        sig_b = {(b[30:23] != 8'd0), b[22:0]};
`else
        exp_a = a[30:23];
        exp_b = b[30:23];
        sig_a = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        sig_b = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
`endif
        a_big    = {exp_a, sig_a} >= {exp_b, sig_b};
        big_c    = a_big ? {sig_a, 1'b0} : {sig_b, 1'b0};
        small_c  = a_big ? {sig_b, 1'b0} : {sig_a, 1'b0};
        ebig_c   = a_big ? exp_a : exp_b;
        esmall_c = a_big ? exp_b : exp_a;
        d_c      = ebig_c - esmall_c;
        sign_c   = a_big ? a[31] : (b[31] ^ op);
        eff_c    = a[31] ^ b[31] ^ op;
    end

    // Gaps of 25 or more push every bit below the guard position into sticky.
    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky_c  = 1'b0;
        if (s1_d >= 8'd25) begin
            sticky_c = |s1_small;
        end else begin
            shifted   = s1_small >> s1_d[4:0];
            lost_mask = (25'd1 << s1_d[4:0]) - 25'd1;
            sticky_c  = |(s1_small & lost_mask);
        end
    end

    // Both stages advance together and freeze together while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_big     <= '0;
            s1_small   <= '0;
            s1_exp     <= '0;
            s1_d       <= '0;
            s1_sign    <= 1'b0;
            s1_eff     <= 1'b0;
            s2_valid   <= 1'b0;
            mant_big   <= '0;
            mant_small <= '0;
            exp_out    <= '0;
            sign_out   <= 1'b0;
            eff_sub    <= 1'b0;
            sticky     <= 1'b0;
        end else if (!stall) begin
            s1_valid   <= in_valid;
            s1_big     <= big_c;
            s1_small   <= small_c;
            s1_exp     <= ebig_c;
            s1_d       <= d_c;
            s1_sign    <= sign_c;
            s1_eff     <= eff_c;
            s2_valid   <= s1_valid;
            mant_big   <= s1_big;
            mant_small <= shifted;
            exp_out    <= s1_exp;
            sign_out   <= s1_sign;
            eff_sub    <= s1_eff;
            sticky     <= sticky_c;
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed vector table, reset/stall sequences and a randomized
// stream scored against an arithmetic model (honours FP_ALIGN_DENORM_EN like the design).
module tb_fp_align_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] mant_big;
    logic [24:0] mant_small;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic        eff_sub;
    logic        sticky;

    typedef struct packed {
        logic [24:0] mb;
        logic [24:0] ms;
        logic [7:0]  e;
        logic        s;
        logic        es;
        logic        st;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        res_t        r;
    } vec_t;

    int   check_count = 0;
    int   pass_count  = 0;
    bit   monitor_on  = 0;
    bit   prev_stall  = 0;
    res_t prev_out;
    res_t exp_q [$];
    vec_t vecs [9];
    logic [31:0] fixed_a [4];
    logic [31:0] fixed_b [4];
    logic        fixed_op [4];

    fp_align_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .exp_out    (exp_out),
        .sign_out   (sign_out),
        .eff_sub    (eff_sub),
        .sticky     (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t dutOut();
        return '{mant_big, mant_small, exp_out, sign_out, eff_sub, sticky};
    endfunction

    // Reference: values as integers, alignment as divide/remainder by 2**d.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic o);
        int     ex, ey, ebig, esm, d;
        longint mx, my, mbig, msm, pw;
        bit     x_big;
        res_t   r;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (longint'(x[22:0]) + ((ex != 0) ? 64'd8388608 : 64'd0)) * 2;
        my = (longint'(y[22:0]) + ((ey != 0) ? 64'd8388608 : 64'd0)) * 2;
`ifdef FP_ALIGN_DENORM_EN
        if (ex == 0) ex = 1;
        if (ey == 0) ey = 1;
`else
        if (ex == 0) mx = 0;
        if (ey == 0) my = 0;
`endif
        x_big = (ex > ey) || (ex == ey && mx >= my);
        ebig  = x_big ? ex : ey;
        esm   = x_big ? ey : ex;
        mbig  = x_big ? mx : my;
        msm   = x_big ? my : mx;
        d     = ebig - esm;
        r.mb  = mbig[24:0];
        r.e   = ebig[7:0];
        if (d >= 25) begin
            r.ms = '0;
            r.st = (msm != 0);
        end else begin
            pw   = longint'(1) << d;
            msm  = msm / pw;
            r.ms = msm[24:0];
            r.st = ((x_big ? my : mx) % pw) != 0;
        end
        r.s  = x_big ? x[31] : (y[31] ^ o);
        r.es = x[31] ^ y[31] ^ o;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        check_count++;
        if (act === expv) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic applyStimulus(input logic [31:0] sa, input logic [31:0] sb, input logic sop);
        in_valid = 1'b1;
        a        = sa;
        b        = sb;
        op       = sop;
    endtask

    task automatic checkResult(input string tag, input res_t r);
        checkOutput({tag, "_mant_big"},   64'(mant_big),   64'(r.mb));
        checkOutput({tag, "_mant_small"}, 64'(mant_small), 64'(r.ms));
        checkOutput({tag, "_exp_out"},    64'(exp_out),    64'(r.e));
        checkOutput({tag, "_sign_out"},   64'(sign_out),   64'(r.s));
        checkOutput({tag, "_eff_sub"},    64'(eff_sub),    64'(r.es));
        checkOutput({tag, "_sticky"},     64'(sticky),     64'(r.st));
    endtask

    // Output side: handshake scoring, stall stability and the in_ready rule.
    always @(negedge clk) begin
        if (monitor_on && !rst) begin
            checkOutput("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                checkOutput("stall_valid_held", 64'(out_valid), 64'd1);
                checkOutput("stall_data_held", 64'(dutOut()), 64'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("stream_result", 64'(dutOut()), 64'(exp_q.pop_front()));
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = dutOut();
    end

    task automatic driveStream(input int n, input bit rnd);
        int          sent, cyc, ea, eb;
        bit          have;
        logic [31:0] na, nb;
        logic        nop;
        sent = 0;
        cyc  = 0;
        have = 0;
        na   = '0;
        nb   = '0;
        nop  = 1'b0;
        while (sent < n && cyc < 5000) begin
            if (!have) begin
                if (rnd) begin
                    ea = $urandom_range(0, 255);
                    if ($urandom_range(0, 1) == 1) begin
                        eb = ea + $urandom_range(0, 60) - 30;
                        if (eb < 0) eb = 0;
                        if (eb > 255) eb = 255;
                    end else begin
                        eb = $urandom_range(0, 255);
                    end
                    na  = {($urandom_range(0, 1) == 1), 8'(ea), 23'($urandom)};
                    nb  = {($urandom_range(0, 1) == 1), 8'(eb), 23'($urandom)};
                    if ($urandom_range(0, 7) == 0) nb = {($urandom_range(0, 1) == 1), na[30:0]};
                    nop  = ($urandom_range(0, 1) == 1);
                    have = ($urandom_range(0, 3) != 0);
                end else begin
                    na   = fixed_a[sent];
                    nb   = fixed_b[sent];
                    nop  = fixed_op[sent];
                    have = 1;
                end
            end
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
            else     out_ready = !(cyc >= 2 && cyc < 5);
            in_valid = have;
            a        = na;
            b        = nb;
            op       = nop;
            @(negedge clk);
            if (have && in_ready) begin
                exp_q.push_back(model(na, nb, nop));
                sent++;
                have = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("stream_all_sent", 64'(sent), 64'(n));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("stream_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, '{25'h1000000, 25'h1000000, 8'h7F, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{32'h3F800000, 32'h3E800000, 1'b0, '{25'h1000000, 25'h0400000, 8'h7F, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{32'h3F800000, 32'h40000000, 1'b1, '{25'h1000000, 25'h0800000, 8'h80, 1'b1, 1'b1, 1'b0}};
        vecs[3] = '{32'h3F800000, 32'h33800001, 1'b0, '{25'h1000000, 25'h0000001, 8'h7F, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{32'h7F000000, 32'h3F800000, 1'b0, '{25'h1000000, 25'h0000000, 8'hFE, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{32'hC0400000, 32'h3F800000, 1'b0, '{25'h1800000, 25'h0800000, 8'h80, 1'b1, 1'b1, 1'b0}};
        vecs[6] = '{32'h3F800000, 32'h3FC00000, 1'b1, '{25'h1800000, 25'h1000000, 8'h7F, 1'b1, 1'b1, 1'b0}};
        vecs[7] = '{32'h7F800000, 32'h3F800000, 1'b0, '{25'h1000000, 25'h0000000, 8'hFF, 1'b0, 1'b0, 1'b1}};
`ifdef FP_ALIGN_DENORM_EN
        vecs[8] = '{32'h00000001, 32'h00800000, 1'b0, '{25'h1000000, 25'h0000002, 8'h01, 1'b0, 1'b0, 1'b0}};
`else
        vecs[8] = '{32'h00000001, 32'h00800000, 1'b0, '{25'h1000000, 25'h0000000, 8'h01, 1'b0, 1'b0, 1'b0}};
`endif
        fixed_a  = '{32'h3F800000, 32'h40490FDB, 32'hC2C80000, 32'h3F800000};
        fixed_b  = '{32'h3E800000, 32'hBF800000, 32'h42C80000, 32'h33800001};
        fixed_op = '{1'b0, 1'b1, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkResult("reset", '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            checkOutput($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checkOutput($sformatf("v%0d_not_early", i), 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'd1);
            checkResult($sformatf("v%0d", i), vecs[i].r);
        end

        // Reset with one pair in S2 and another in S1: nothing may emerge afterwards.
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkResult("midreset", '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midreset_quiet%0d", i), 64'(out_valid), 64'd0);
        end

        monitor_on = 1;
        driveStream(4, 1'b0);
        driveStream(300, 1'b1);
        monitor_on = 0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
